// File: rtl/power_pipe_arbiter.sv
// rtl/power_pipe_arbiter.sv - round-robin front end sharing one fixed-latency x^8 datapath
// Tags ride alongside the datapath so each result returns to the requester that issued it.
module power_pipe_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_LAT   = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          pipe_valid,
    output logic [DATA_WIDTH-1:0]         pipe_data,
    input  logic                          pipe_rsp_valid,
    input  logic [63:0]                   pipe_rsp_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [63:0]                   rsp_data,
    output logic                          busy,
    output logic                          err
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]             ptr_q, ptr_d;
    logic                        found_hi, found_lo;
    logic [ID_W-1:0]             id_hi, id_lo;
    logic                        gnt_found;
    logic [ID_W-1:0]             gnt_id;
    logic                        accept;
    logic [DATA_WIDTH-1:0]       gnt_data;
    logic [DATA_WIDTH-1:0]       pipe_data_q, pipe_data_d;
    // Stage 0 travels with pipe_valid; stage PIPE_LAT lines up with pipe_rsp_valid.
    logic [PIPE_LAT:0]           tag_v_q, tag_v_d;
    logic [PIPE_LAT:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [63:0]                 rsp_data_q, rsp_data_d;
    logic                        err_q, err_d;
    logic                        rsp_hit, rsp_mismatch;

    // Two-pass search: first requester at or above ptr, else the lowest one (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        id_hi    = '0;
        id_lo    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_hi && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                id_hi    = ID_W'(i);
            end
            if (!found_lo && req_valid[i]) begin
                found_lo = 1'b1;
                id_lo    = ID_W'(i);
            end
        end
        gnt_found = found_hi | found_lo;
        gnt_id    = found_hi ? id_hi : id_lo;
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept    = enable & ~reset & gnt_found;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;

    assign rsp_hit      = pipe_rsp_valid & tag_v_q[PIPE_LAT];
    assign rsp_mismatch = pipe_rsp_valid ^ tag_v_q[PIPE_LAT];

    always_comb begin
        ptr_d       = ptr_q;
        pipe_data_d = pipe_data_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q | rsp_mismatch;
        tag_v_d     = {tag_v_q[PIPE_LAT-1:0], accept};
        tag_id_d    = {tag_id_q[PIPE_LAT-1:0], gnt_id};
        if (accept) begin
            ptr_d       = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            pipe_data_d = gnt_data;
        end
        if (rsp_hit) begin
            rsp_valid_d = NUM_REQ'(1) << tag_id_q[PIPE_LAT];
            rsp_data_d  = pipe_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            pipe_data_q <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            pipe_data_q <= pipe_data_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign pipe_valid = tag_v_q[0];
    assign pipe_data  = pipe_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = |tag_v_q;
    assign err        = err_q;

endmodule

// File: tb/tb_power_pipe_arbiter.sv
// tb/tb_power_pipe_arbiter.sv - directed and randomized bench with a queue-based reference model
module tb_power_pipe_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int PIPE_LAT   = 3;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          enable;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          pipe_valid;
    logic [DATA_WIDTH-1:0]         pipe_data;
    logic                          pipe_rsp_valid;
    logic [63:0]                   pipe_rsp_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [63:0]                   rsp_data;
    logic                          busy;
    logic                          err;

    logic [DATA_WIDTH-1:0] rd [NUM_REQ];

    int n_cmp = 0;
    int n_bad = 0;

    power_pipe_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pipe_valid(pipe_valid), .pipe_data(pipe_data),
        .pipe_rsp_valid(pipe_rsp_valid), .pipe_rsp_data(pipe_rsp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = rd[i];
    end

    function automatic logic [63:0] pow8(input logic [DATA_WIDTH-1:0] x);
        logic [63:0] p;
        p = 64'(x);
        p = p * p;
        p = p * p;
        p = p * p;
        return p;
    endfunction

    // Datapath stand-in: x^8 mod 2^64, PIPE_LAT cycles, never reset.
    logic [PIPE_LAT-1:0] dp_v = '0;
    logic [63:0]         dp_d [PIPE_LAT];
    always @(posedge clk) begin
        dp_v     <= {dp_v[PIPE_LAT-2:0], pipe_valid};
        dp_d[0]  <= pow8(pipe_data);
        for (int j = 1; j < PIPE_LAT; j++) dp_d[j] <= dp_d[j-1];
    end
    assign pipe_rsp_valid = dp_v[PIPE_LAT-1];
    assign pipe_rsp_data  = dp_d[PIPE_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (p + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        int          t;
        int          id;
        logic [63:0] res;
    } op_t;

    op_t                   ops[$];
    int                    cyc     = 0;
    int                    ptr_m   = 0;
    bit                    started = 1'b0;
    bit                    e_pv    = 1'b0;
    logic [DATA_WIDTH-1:0] e_pd    = '0;
    logic [NUM_REQ-1:0]    e_rv    = '0;
    logic [63:0]           e_rd    = '0;
    bit                    e_err   = 1'b0;
    int                    g;
    bit                    ret;

    // An accepted op is in flight from the cycle after accept until its datapath return cycle.
    always @(negedge clk) begin
        cyc++;
        g = (!reset && enable) ? model_grant(req_valid, ptr_m) : -1;
        if (started) begin
            chk("req_ready",  64'(req_ready),  (g >= 0) ? 64'(1 << g) : 64'd0);
            chk("pipe_valid", 64'(pipe_valid), 64'(e_pv));
            chk("pipe_data",  64'(pipe_data),  64'(e_pd));
            chk("rsp_valid",  64'(rsp_valid),  64'(e_rv));
            chk("rsp_data",   rsp_data,        e_rd);
            chk("busy",       64'(busy),       64'(ops.size() != 0));
            chk("err",        64'(err),        64'(e_err));
        end
        if (reset) begin
            ptr_m   = 0;
            ops.delete();
            e_pv    = 1'b0;
            e_pd    = '0;
            e_rv    = '0;
            e_rd    = '0;
            e_err   = 1'b0;
            started = 1'b1;
        end else begin
            ret  = (ops.size() != 0) && (ops[0].t + PIPE_LAT + 1 == cyc);
            e_rv = '0;
            if (pipe_rsp_valid && ret) begin
                e_rv = NUM_REQ'(1 << ops[0].id);
                e_rd = ops[0].res;
            end
            if (pipe_rsp_valid != ret) e_err = 1'b1;
            if (ret) void'(ops.pop_front());
            e_pv = (g >= 0);
            if (g >= 0) begin
                e_pd = rd[g];
                ops.push_back('{t: cyc, id: g, res: pow8(rd[g])});
                ptr_m = (g + 1) % NUM_REQ;
            end
        end
    end

    task automatic pe();
        @(posedge clk);
        #1;
    endtask

    task automatic nb();
        @(negedge clk);
    endtask

    logic [63:0]        t2_res [NUM_REQ];
    logic [NUM_REQ-1:0] acc;

    initial begin
        t2_res[0] = 64'd1;
        t2_res[1] = 64'd256;
        t2_res[2] = 64'd6561;
        t2_res[3] = 64'd65536;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = '0;
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = '1;
        repeat (5) pe();
        nb();
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset busy",      64'(busy),      64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);

        // Single op, data 3
        pe();
        reset = 1'b0; req_valid = 4'b0001; rd[0] = 32'd3;
        nb(); chk("t1 grant", 64'(req_ready), 64'h1);
        pe(); req_valid = '0;
        nb(); chk("t1 pipe_valid", 64'(pipe_valid), 64'h1); chk("t1 pipe_data", 64'(pipe_data), 64'd3);
        repeat (3) pe();
        nb(); chk("t1 busy in flight", 64'(busy), 64'h1);
        pe();
        nb();
        chk("t1 rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1 rsp_data",  rsp_data,       64'd6561);
        chk("t1 busy done", 64'(busy),      64'h0);

        // All four requesters continuously valid, pointer from 0
        pe(); reset = 1'b1;
        pe(); reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = DATA_WIDTH'(i + 1);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) pe();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            nb();
            if (k < 8) chk("t2 grant", 64'(req_ready), 64'(1 << (k % 4)));
            if (k >= 1 && k <= 8) chk("t2 issue", 64'(pipe_valid), 64'h1);
            if (k >= 5) begin
                chk("t2 rsp_valid", 64'(rsp_valid), 64'(1 << ((k - 5) % 4)));
                chk("t2 rsp_data",  rsp_data,       t2_res[(k - 5) % 4]);
            end
        end

        // Fairness between requesters 2 and 3
        pe(); req_valid = 4'b0100;
        nb(); chk("t3 grant a", 64'(req_ready), 64'h4);
        pe(); req_valid = 4'b1100;
        nb(); chk("t3 grant b", 64'(req_ready), 64'h8);
        pe();
        nb(); chk("t3 grant c", 64'(req_ready), 64'h4);
        pe();
        nb(); chk("t3 grant d", 64'(req_ready), 64'h8);
        pe(); req_valid = '0;
        repeat (6) pe();

        // enable low with two ops in flight
        req_valid = 4'b0001;
        nb(); chk("t4 grant 0", 64'(req_ready), 64'h1);
        pe(); req_valid = 4'b0100;
        nb(); chk("t4 grant 2", 64'(req_ready), 64'h4);
        pe(); enable = 1'b0; req_valid = 4'b0010;
        nb(); chk("t4 blocked", 64'(req_ready), 64'h0);
        repeat (5) pe();
        nb(); chk("t4 drained", 64'(busy), 64'h0);
        pe(); enable = 1'b1;
        nb(); chk("t4 resume", 64'(req_ready), 64'h2);
        pe(); req_valid = '0;
        repeat (6) pe();

        // Reset with three ops in flight; datapath keeps running
        req_valid = 4'b0001;
        pe(); req_valid = 4'b0010;
        pe(); req_valid = 4'b0100;
        pe(); req_valid = '0; reset = 1'b1;
        pe(); reset = 1'b0;
        nb();
        chk("t5 pipe_valid", 64'(pipe_valid), 64'h0);
        chk("t5 busy",       64'(busy),       64'h0);
        chk("t5 err clear",  64'(err),        64'h0);
        repeat (3) pe();
        nb();
        chk("t5 err set",    64'(err),        64'h1);
        chk("t5 rsp_valid",  64'(rsp_valid),  64'h0);

        // All-ones operand: datapath keeps the low 64 bits of x^8
        pe(); reset = 1'b1;
        pe(); reset = 1'b0; req_valid = 4'b0001; rd[0] = 32'hFFFF_FFFF;
        pe(); req_valid = '0;
        repeat (4) pe();
        nb();
        chk("t6 rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t6 rsp_data",  rsp_data,       64'hFFFF_FFF8_0000_0001);

        // Randomized traffic; requesters hold until accepted
        for (int n = 0; n < 3000; n++) begin
            nb();
            acc = req_valid & req_ready;
            pe();
            reset  = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    rd[i] = ($urandom_range(0, 1) == 0) ? DATA_WIDTH'($urandom_range(0, 300)) : $urandom;
                end
            end
        end
        pe(); reset = 1'b0; req_valid = '0; enable = 1'b1;
        repeat (10) pe();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
